// File: rtl/ow_serializer_pkg.sv
// Shared types and defaults for the IMC output wrapper (ow_serializer).
// The header helper is used only when OW_HEADER_EN is defined.
package ow_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      SEND
   } ow_state_t;

   localparam int W_DEF      = 16;
   localparam int NWORDS_DEF = 4;

   // Header word layout: frame sequence number above the bundle length.
   function automatic logic [15:0] make_hdr(input logic [7:0] seq, input logic [7:0] n);
      return {seq, n};
   endfunction

endpackage

// File: rtl/ow_serializer_if.sv
// Bundle-capture and word-stream signals of the IMC output wrapper.
// master = ow_serializer side, slave = IMC producer plus downstream consumer.
interface ow_serializer_if
   import ow_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int NWORDS = NWORDS_DEF
);

   logic                imc_done;
   logic [NWORDS*W-1:0] result;
   logic                res_ready;
   logic                dataReady;
   logic [W-1:0]        dataOut;
   logic                dataAccept;

   modport master (
      input  imc_done,
      input  result,
      input  dataAccept,
      output res_ready,
      output dataReady,
      output dataOut
   );

   modport slave (
      output imc_done,
      output result,
      output dataAccept,
      input  res_ready,
      input  dataReady,
      input  dataOut
   );

endinterface

// File: rtl/ow_serializer.sv
// IMC output wrapper: captures one result bundle on imc_done and streams it LSW first over dataReady/dataAccept.
// Define OW_HEADER_EN to prefix every frame with a {seq, NWORDS} header word (needs W >= 16).
module ow_serializer
   import ow_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int NWORDS = NWORDS_DEF
) (
   input logic             clk,
   input logic             rst,
   ow_serializer_if.master bus
);

   localparam int              IDXW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

   ow_state_t           state;
   logic [NWORDS*W-1:0] data_buf;
   logic [IDXW-1:0]     idx;
`ifdef OW_HEADER_EN
   logic [7:0]          seq;
`endif

   function automatic logic [W-1:0] word_at(input logic [NWORDS*W-1:0] b, input logic [IDXW-1:0] k);
      return b[int'(k)*W +: W];
   endfunction

   // The next word is loaded on the same edge that retires the current one, so a
   // consumer holding dataAccept high sees one word per cycle with no bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         data_buf      <= '0;
         bus.res_ready <= 1'b1;
         bus.dataReady <= 1'b0;
         bus.dataOut   <= '0;
`ifdef OW_HEADER_EN
         seq           <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.imc_done) begin
                  data_buf      <= bus.result;
                  idx           <= '0;
                  bus.res_ready <= 1'b0;
                  bus.dataReady <= 1'b1;
`ifdef OW_HEADER_EN
                  state         <= HDR;
                  bus.dataOut   <= W'(make_hdr(seq, 8'(NWORDS)));
`else
                  state         <= SEND;
                  bus.dataOut   <= bus.result[W-1:0];
`endif
               end
            end
`ifdef OW_HEADER_EN
            HDR: begin
               if (bus.dataAccept) begin
                  state       <= SEND;
                  bus.dataOut <= data_buf[W-1:0];
               end
            end
`endif
            SEND: begin
               if (bus.dataAccept) begin
                  if (idx == LAST_IDX) begin
                     state         <= IDLE;
                     idx           <= '0;
                     bus.res_ready <= 1'b1;
                     bus.dataReady <= 1'b0;
                     bus.dataOut   <= '0;
`ifdef OW_HEADER_EN
                     seq           <= seq + 8'd1;
`endif
                  end else begin
                     idx         <= idx + IDXW'(1);
                     bus.dataOut <= word_at(data_buf, idx + IDXW'(1));
                  end
               end
            end
            default: begin
               state         <= IDLE;
               idx           <= '0;
               bus.res_ready <= 1'b1;
               bus.dataReady <= 1'b0;
               bus.dataOut   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ow_serializer.sv
// Scoreboard bench for ow_serializer: expected words are queued at capture and popped on each transfer.
// Build with OW_HEADER_EN defined to also exercise header words and the seq wrap.
module tb_ow_serializer;
   import ow_pkg::*;

   localparam int W      = W_DEF;
   localparam int NWORDS = NWORDS_DEF;
`ifdef OW_HEADER_EN
   localparam int HDR_WORDS = 1;
   localparam int N_BURST   = 257;
`else
   localparam int HDR_WORDS = 0;
   localparam int N_BURST   = 4;
`endif

   localparam logic [NWORDS*W-1:0] BUNDLE_A = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
   localparam logic [NWORDS*W-1:0] BUNDLE_B = {16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678};

   logic         clk = 1'b0;
   logic         rst;
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0]   exp_seq = 8'd0;
   logic         hold_valid = 1'b0;
   logic [W-1:0] hold_val   = '0;

   ow_serializer_if #(.W(W), .NWORDS(NWORDS)) bus ();

   ow_serializer #(.W(W), .NWORDS(NWORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected words of one frame, in the order the consumer must see them.
   task automatic push_frame(input logic [NWORDS*W-1:0] bundle);
`ifdef OW_HEADER_EN
      exp_q.push_back(W'({exp_seq, 8'(NWORDS)}));
      exp_seq++;
`endif
      for (int k = 0; k < NWORDS; k++) exp_q.push_back(bundle[k*W +: W]);
   endtask

   // Called just after a rising edge; captures on the following edge.
   task automatic apply_stimulus(input logic [NWORDS*W-1:0] bundle);
      for (int i = 0; i < 50 && !bus.res_ready; i++) begin
         @(posedge clk); #1;
      end
      check_output("res_ready_before_capture", W'(bus.res_ready), W'(1));
      bus.result   = bundle;
      bus.imc_done = 1'b1;
      push_frame(bundle);
      @(posedge clk); #1;
      bus.imc_done = 1'b0;
   endtask

   task automatic drain(input int period);
      for (int c = 0; c < 400; c++) begin
         if (exp_q.size() == 0 && !bus.dataReady) break;
         bus.dataAccept = ((c % period) == period - 1);
         @(posedge clk); #1;
      end
      bus.dataAccept = 1'b0;
      check_output("drain_empty", W'(exp_q.size()), '0);
      check_output("drain_idle", W'(bus.dataReady), '0);
      check_output("drain_res_ready", W'(bus.res_ready), W'(1));
   endtask

   // Monitor: every transfer must match the scoreboard head; a waiting word must not move.
   always @(negedge clk) begin
      if (!rst && bus.dataReady) begin
         if (hold_valid) check_output("word_stable", bus.dataOut, hold_val);
         if (bus.dataAccept) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("[TB] FAIL unexpected_word: observed %h expected no transfer", bus.dataOut);
            end
            if (exp_q.size() != 0) check_output("word", bus.dataOut, exp_q.pop_front());
            hold_valid = 1'b0;
         end else begin
            hold_valid = 1'b1;
            hold_val   = bus.dataOut;
         end
      end else begin
         hold_valid = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NWORDS*W-1:0] rb;
      logic                got_b;

      rst            = 1'b1;
      bus.imc_done   = 1'b0;
      bus.result     = '0;
      bus.dataAccept = 1'b0;

      // Reset held for three cycles
      #1;
      check_output("rst_ready", W'(bus.dataReady), '0);
      check_output("rst_out", bus.dataOut, '0);
      check_output("rst_res_ready", W'(bus.res_ready), W'(1));
      repeat (3) begin
         @(negedge clk);
         check_output("rst_ready", W'(bus.dataReady), '0);
         check_output("rst_out", bus.dataOut, '0);
         check_output("rst_res_ready", W'(bus.res_ready), W'(1));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("post_rst_ready", W'(bus.dataReady), '0);
      check_output("post_rst_res_ready", W'(bus.res_ready), W'(1));
      @(posedge clk); #1;

      $display("[TB] streaming frame with dataAccept held high");
      bus.dataAccept = 1'b1;
      apply_stimulus(BUNDLE_A);
      for (int k = 0; k < NWORDS + HDR_WORDS; k++) begin
         @(negedge clk);
         check_output("stream_ready", W'(bus.dataReady), W'(1));
         check_output("stream_res_busy", W'(bus.res_ready), '0);
         @(posedge clk); #1;
      end
      check_output("end_ready", W'(bus.dataReady), '0);
      check_output("end_out", bus.dataOut, '0);
      check_output("end_res_ready", W'(bus.res_ready), W'(1));
      check_output("end_queue", W'(exp_q.size()), '0);

      // dataAccept while idle must not start anything
      repeat (3) begin
         @(posedge clk); #1;
         check_output("idle_accept_ready", W'(bus.dataReady), '0);
         check_output("idle_accept_res_ready", W'(bus.res_ready), W'(1));
      end
      bus.dataAccept = 1'b0;

      $display("[TB] accept pulsed every third cycle");
      apply_stimulus(BUNDLE_A);
      drain(3);

      $display("[TB] imc_done during SEND");
      bus.dataAccept = 1'b1;
      apply_stimulus(BUNDLE_A);
      bus.result   = BUNDLE_B;
      bus.imc_done = 1'b1;
      got_b        = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.res_ready) begin
            push_frame(BUNDLE_B);
            @(posedge clk); #1;
            got_b = 1'b1;
            break;
         end
      end
      bus.imc_done = 1'b0;
      check_output("frame_b_captured", W'(got_b), W'(1));
      drain(1);

      $display("[TB] reset after second transfer");
      bus.dataAccept = 1'b1;
      apply_stimulus(BUNDLE_A);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      exp_seq = 8'd0;
      #1;
      check_output("midrst_ready", W'(bus.dataReady), '0);
      check_output("midrst_out", bus.dataOut, '0);
      check_output("midrst_res_ready", W'(bus.res_ready), W'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      apply_stimulus(BUNDLE_B);
      drain(1);

      $display("[TB] burst of %0d random frames", N_BURST);
      for (int f = 0; f < N_BURST; f++) begin
         for (int k = 0; k < NWORDS; k++) rb[k*W +: W] = W'($urandom);
         bus.dataAccept = 1'b1;
         apply_stimulus(rb);
         drain(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
